// File: rtl/oracle_commit_checker_if.sv
// Handshake bundle between the oracle/core side and the commit checker:
// the expected-record push channel and the core commit event channel.
interface oracle_commit_checker_if #(
    parameter int unsigned XLEN = 64,
    parameter int unsigned ID_W = 8
);
    logic            exp_valid_i;
    logic            exp_ready_o;
    logic [XLEN-1:0] exp_pc_i;
    logic [XLEN-1:0] exp_rdval_i;
    logic            exp_has_rd_i;

    logic            cmt_valid_i;
    logic [ID_W-1:0] cmt_id_i;
    logic [XLEN-1:0] cmt_pc_i;
    logic [XLEN-1:0] cmt_rdval_i;
    logic            cmt_has_rd_i;

    modport master (
        output exp_valid_i, exp_pc_i, exp_rdval_i, exp_has_rd_i,
        output cmt_valid_i, cmt_id_i, cmt_pc_i, cmt_rdval_i, cmt_has_rd_i,
        input  exp_ready_o
    );

    modport slave (
        input  exp_valid_i, exp_pc_i, exp_rdval_i, exp_has_rd_i,
        input  cmt_valid_i, cmt_id_i, cmt_pc_i, cmt_rdval_i, cmt_has_rd_i,
        output exp_ready_o
    );
endinterface

// File: rtl/oracle_commit_checker.sv
// Buffers golden-model commit records and checks them against core commits;
// the first divergence or watchdog expiry is latched as a sticky error.
module oracle_commit_checker #(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned XLEN    = 64,
    parameter int unsigned ID_W    = 8,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      clr_i,
    oracle_commit_checker_if.slave    bus,
    output logic                      err_o,
    output logic [2:0]                err_code_o,
    output logic [ID_W-1:0]           err_id_o,
    output logic [XLEN-1:0]           err_pc_o,
    output logic [31:0]               commit_cnt_o,
    output logic [$clog2(DEPTH):0]    level_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [2:0] CODE_PC    = 3'd1;
    localparam logic [2:0] CODE_RD    = 3'd2;
    localparam logic [2:0] CODE_UNDER = 3'd3;
    localparam logic [2:0] CODE_TOUT  = 3'd4;

    typedef enum logic {
        S_RUN,
        S_HALT
    } state_t;

    state_t state, state_next;

    logic [XLEN-1:0] mem_pc    [DEPTH];
    logic [XLEN-1:0] mem_rdval [DEPTH];
    logic            mem_has_rd[DEPTH];

    logic [PTR_W:0]  wr_ptr, rd_ptr;
    logic [WD_W-1:0] wd_cnt, wd_next;

    logic            empty, full;
    logic [XLEN-1:0] head_pc, head_rdval;
    logic            head_has_rd;
    logic            pc_bad, rd_bad;

    logic            push, pop, cnt_inc, err_set;
    logic [2:0]      code_next;
    logic [ID_W-1:0] id_next;
    logic [XLEN-1:0] pc_next;

    // Same index with opposite wrap bits means the FIFO has lapped the reader.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

    assign head_pc     = mem_pc[rd_ptr[PTR_W-1:0]];
    assign head_rdval  = mem_rdval[rd_ptr[PTR_W-1:0]];
    assign head_has_rd = mem_has_rd[rd_ptr[PTR_W-1:0]];

    assign pc_bad = (bus.cmt_pc_i != head_pc);
    assign rd_bad = (bus.cmt_has_rd_i != head_has_rd) ||
                    (head_has_rd && (bus.cmt_rdval_i != head_rdval));

    assign bus.exp_ready_o = (state == S_RUN) && !full;
    assign err_o           = (state == S_HALT);
    assign level_o         = wr_ptr - rd_ptr;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= S_RUN;
        end else if (clr_i) begin
            state <= S_RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        push       = 1'b0;
        pop        = 1'b0;
        cnt_inc    = 1'b0;
        err_set    = 1'b0;
        code_next  = '0;
        id_next    = '0;
        pc_next    = '0;
        wd_next    = '0;

        case (state)
            S_RUN: begin
                push = bus.exp_valid_i && !full;
                if (bus.cmt_valid_i) begin
                    if (empty) begin
                        err_set   = 1'b1;
                        code_next = CODE_UNDER;
                        id_next   = bus.cmt_id_i;
                        pc_next   = bus.cmt_pc_i;
                    end else begin
                        pop = 1'b1;
                        if (pc_bad || rd_bad) begin
                            err_set   = 1'b1;
                            code_next = pc_bad ? CODE_PC : CODE_RD;
                            id_next   = bus.cmt_id_i;
                            pc_next   = bus.cmt_pc_i;
                        end else begin
                            cnt_inc = 1'b1;
                        end
                    end
                end else if (!empty && (TIMEOUT != 0)) begin
                    // Fires in the cycle after the counter has reached the limit.
                    if (wd_cnt >= WD_W'(TIMEOUT)) begin
                        err_set   = 1'b1;
                        code_next = CODE_TOUT;
                        pc_next   = head_pc;
                    end else begin
                        wd_next = wd_cnt + 1'b1;
                    end
                end
                if (err_set) begin
                    state_next = S_HALT;
                end
            end
            default: begin
                state_next = state;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            wd_cnt       <= '0;
            commit_cnt_o <= '0;
            err_code_o   <= '0;
            err_id_o     <= '0;
            err_pc_o     <= '0;
        end else if (clr_i) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            wd_cnt       <= '0;
            commit_cnt_o <= '0;
            err_code_o   <= '0;
            err_id_o     <= '0;
            err_pc_o     <= '0;
        end else begin
            wd_cnt <= wd_next;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (cnt_inc) begin
                commit_cnt_o <= commit_cnt_o + 32'd1;
            end
            if (err_set) begin
                err_code_o <= code_next;
                err_id_o   <= id_next;
                err_pc_o   <= pc_next;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push && !clr_i) begin
            mem_pc[wr_ptr[PTR_W-1:0]]     <= bus.exp_pc_i;
            mem_rdval[wr_ptr[PTR_W-1:0]]  <= bus.exp_rdval_i;
            mem_has_rd[wr_ptr[PTR_W-1:0]] <= bus.exp_has_rd_i;
        end
    end
endmodule
